// File: rtl/multicycle_pkg.sv
// multicycle_pkg
// Shared encodings for the multicycle MIPS control path: FSM state values,
// supported opcodes and the datapath mux select encodings driven by the
// control unit. Imported by multicycle_out_decode and multicycle_control.
package multicycle_pkg;

  // FSM state encodings. The state register is kept as plain logic [3:0]
  // so that the unencoded values 12..15 remain representable.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_EXEC    = 4'd6,
    ST_ALU_WB  = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_ADDI_EX = 4'd10,
    ST_ADDI_WB = 4'd11
  } state_t;

  // Opcode field, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_out_decode.sv
// multicycle_out_decode
// Purely combinational state -> control-word decoder. Produces the raw
// per-state control values; handshake gating and reset masking are applied
// by the FSM module.
// Ports:
//   state          in   4  current FSM state
//   pc_write       out  1  unconditional PC load (raw, FETCH value ungated)
//   pc_write_cond  out  1  PC load on ALU zero
//   iord           out  1  memory address select
//   mem_read       out  1  memory read request
//   mem_write      out  1  memory write request
//   ir_write       out  1  IR load (raw, ungated)
//   mem_to_reg     out  1  register write data select
//   reg_dst        out  1  write register select
//   reg_write      out  1  register file write enable
//   alu_src_a      out  1  ALU A select
//   alu_src_b      out  2  ALU B select
//   alu_op         out  2  ALU operation
//   pc_source      out  2  PC source select
module multicycle_out_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      ST_FETCH: begin
        // PC + 4 computed on the ALU; write enables are qualified upstream
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      ST_DECODE: begin
        // speculative branch target into ALUOut
        alu_src_b = SRCB_IMM_SH;
      end
      ST_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: ;  // unencoded states: everything stays 0
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for the multicycle MIPS core. Sequences the shared
// datapath through fetch/decode/execute/memory/writeback, stalls on the
// memory handshake and pulses illegal_op on unsupported opcodes.
// Optional build macro MULTICYCLE_PERF_CNT_EN adds cycle/instruction
// counters (cycle_count, instr_count).
// Ports:
//   clk, rst        core clock; synchronous active-high reset
//   opcode          IR[31:26]
//   mem_ready       memory completes current access this cycle
//   PCWrite .. PCSource  datapath control word (see multicycle_pkg)
//   illegal_op      one-cycle pulse in DECODE on an unsupported opcode
//   state           current state for debug (reads 0 during reset)
//   cycle_count, instr_count  performance counters (macro builds only)
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        illegal_op,
  output logic [3:0]  state
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  logic [3:0] state_q, state_d;

  // ---------------- state register / next state ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:  state_d = ST_FETCH;
      ST_MEM_WR:  if (mem_ready) state_d = ST_FETCH;
      ST_EXEC:    state_d = ST_ALU_WB;
      ST_ALU_WB:  state_d = ST_FETCH;
      ST_BRANCH:  state_d = ST_FETCH;
      ST_JUMP:    state_d = ST_FETCH;
      ST_ADDI_EX: state_d = ST_ADDI_WB;
      ST_ADDI_WB: state_d = ST_FETCH;
      default:    state_d = ST_FETCH;  // recover from unencoded values
    endcase
  end

  // ---------------- control word ----------------
  logic       pc_write_raw, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write_raw, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  multicycle_out_decode u_dec (
    .state         (state_q),
    .pc_write      (pc_write_raw),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write_raw),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source)
  );

  // IR and PC+4 may only be committed once the fetch read has returned.
  // JUMP also raises PCWrite and must not be held off by mem_ready.
  logic in_fetch, fetch_ok, run;
  assign in_fetch = (state_q == ST_FETCH);
  assign fetch_ok = ~in_fetch | mem_ready;
  // Every output is forced low while reset is held, independent of state_q.
  assign run      = ~rst;

  assign PCWrite     = run & pc_write_raw & fetch_ok;
  assign IRWrite     = run & ir_write_raw & mem_ready;
  assign PCWriteCond = run & pc_write_cond;
  assign IorD        = run & iord;
  assign MemRead     = run & mem_read;
  assign MemWrite    = run & mem_write;
  assign MemtoReg    = run & mem_to_reg;
  assign RegDst      = run & reg_dst;
  assign RegWrite    = run & reg_write;
  assign ALUSrcA     = run & alu_src_a;
  assign ALUSrcB     = run ? alu_src_b : 2'b00;
  assign ALUOp       = run ? alu_op    : 2'b00;
  assign PCSource    = run ? pc_source : 2'b00;
  assign illegal_op  = run & (state_q == ST_DECODE) & ~op_supported(opcode);
  assign state       = run ? state_q : 4'd0;

`ifdef MULTICYCLE_PERF_CNT_EN
  // ---------------- performance counters ----------------
  logic [31:0] cyc_q, ins_q;
  logic        instr_done;

  // Any return to FETCH retires an instruction, including illegal ones.
  assign instr_done = ~in_fetch & (state_d == ST_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (instr_done) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_count = run ? cyc_q : 32'd0;
  assign instr_count = run ? ins_q : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Scoreboard bench: each driven cycle pushes the expected state and control
// word (derived from the state table below) to a queue; the DUT outputs are
// sampled on the falling edge and compared against the popped entry.
// Define MULTICYCLE_PERF_CNT_EN to also check the performance counters.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
`ifdef MULTICYCLE_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

  // control word bit positions
  localparam int PCW = 16, PCWC = 15, IORD = 14, MRD = 13, MWR = 12, IRW = 11;
  localparam int M2R = 10, RDST = 9, RWR = 8, SRCA = 7, ILL = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctrl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected control word for state s with the given live inputs.
  function automatic logic [16:0] exp_ctrl(input logic r, input logic [3:0] s,
                                           input logic [5:0] op, input logic mr);
    logic [16:0] c;
    c = '0;
    if (!r) begin
      case (s)
        4'd0:  begin c[MRD] = 1; c[6:5] = 2'b01; c[IRW] = mr; c[PCW] = mr; end
        4'd1:  begin
                 c[6:5] = 2'b11;
                 c[ILL] = !(op inside {R, LW, SW, BEQ, J, ADDI});
               end
        4'd2:  begin c[SRCA] = 1; c[6:5] = 2'b10; end
        4'd3:  begin c[MRD] = 1; c[IORD] = 1; end
        4'd4:  begin c[RWR] = 1; c[M2R] = 1; end
        4'd5:  begin c[MWR] = 1; c[IORD] = 1; end
        4'd6:  begin c[SRCA] = 1; c[4:3] = 2'b10; end
        4'd7:  begin c[RWR] = 1; c[RDST] = 1; end
        4'd8:  begin c[SRCA] = 1; c[4:3] = 2'b01; c[PCWC] = 1; c[2:1] = 2'b01; end
        4'd9:  begin c[PCW] = 1; c[2:1] = 2'b10; end
        4'd10: begin c[SRCA] = 1; c[6:5] = 2'b10; end
        4'd11: begin c[RWR] = 1; end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // One cycle: drive inputs, push expectation, sample mid-cycle, advance.
  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] es);
    exp_t e, got;
    rst = r; opcode = op; mem_ready = mr;
    e.st   = r ? 4'd0 : es;
    e.ctrl = exp_ctrl(r, es, op, mr);
    q.push_back(e);
    @(negedge clk);
    got.st   = state;
    got.ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, illegal_op};
    if (q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("state", {28'd0, got.st}, {28'd0, e.st});
      chk("ctrl", {15'd0, got.ctrl}, {15'd0, e.ctrl});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; opcode = R; mem_ready = 1'b0;
    @(posedge clk); #1;

    // reset from unknown state
    step(1, R, 0, 0);
    step(1, R, 1, 0);

    // back-to-back R-type, addi, sw with mem_ready=1 (12 cycles)
    step(0, R, 1, 0);    step(0, R, 1, 1);    step(0, R, 1, 6);    step(0, R, 1, 7);
    step(0, ADDI, 1, 0); step(0, ADDI, 1, 1); step(0, ADDI, 1, 10); step(0, ADDI, 1, 11);
    step(0, SW, 1, 0);   step(0, SW, 1, 1);   step(0, SW, 1, 2);   step(0, SW, 1, 5);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("cycle_count", cycle_count, 32'd12);
    chk("instr_count", instr_count, 32'd3);
`endif

    // lw with mem_ready held at 1: 0,1,2,3,4
    step(0, LW, 1, 0); step(0, LW, 1, 1); step(0, LW, 1, 2);
    step(0, LW, 1, 3); step(0, LW, 1, 4);

    // FETCH wait 3 cycles, then R-type with mem_ready ignored outside memory states
    step(0, R, 0, 0); step(0, R, 0, 0); step(0, R, 0, 0); step(0, R, 1, 0);
    step(0, R, 0, 1); step(0, R, 0, 6); step(0, R, 0, 7);

    // beq and j
    step(0, BEQ, 1, 0); step(0, BEQ, 1, 1); step(0, BEQ, 1, 8);
    step(0, J, 1, 0);   step(0, J, 0, 1);   step(0, J, 0, 9);

    // sw with 2-cycle write wait
    step(0, SW, 1, 0); step(0, SW, 1, 1); step(0, SW, 0, 2);
    step(0, SW, 0, 5); step(0, SW, 0, 5); step(0, SW, 1, 5);

    // lw with 1-cycle read wait
    step(0, LW, 1, 0); step(0, LW, 1, 1); step(0, LW, 1, 2);
    step(0, LW, 0, 3); step(0, LW, 1, 3); step(0, LW, 1, 4);

    // illegal opcodes: pulse only in DECODE, straight back to FETCH
    step(0, 6'b111111, 1, 0); step(0, 6'b111111, 1, 1);
    step(0, 6'b000011, 1, 0); step(0, 6'b000011, 1, 1);

    // reset in the middle of a MEM_RD wait
    step(0, LW, 1, 0); step(0, LW, 1, 1); step(0, LW, 0, 2); step(0, LW, 0, 3);
    step(1, LW, 0, 3); step(1, LW, 0, 0);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("cnt_rst", instr_count | cycle_count, 32'd0);
`endif
    step(0, LW, 0, 0); step(0, LW, 1, 0); step(0, LW, 1, 1);
    step(0, LW, 1, 2); step(0, LW, 1, 3); step(0, LW, 1, 4);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("instr_after_rst", instr_count, 32'd1);
    chk("cycle_after_rst", cycle_count, 32'd6);
`endif
    step(0, R, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
